// File: rtl/vga_pkg.sv
// VGA timing package: default 640x480@60 constants and coordinate type.
// Shared by the sync generator, its interface and the pixel divider.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL =
        H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL =
        V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: syncs, blanking, pixel strobes and coordinates.
// master drives the timing, slave consumes it.
interface vga_sync_if;
    import vga_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    logic   frame_tick;
    coord_t pixel_x;
    coord_t pixel_y;

    modport master (
        output hsync, vsync, video_on, p_tick,
        output frame_tick, pixel_x, pixel_y
    );

    modport slave (
        input hsync, vsync, video_on, p_tick,
        input frame_tick, pixel_x, pixel_y
    );

endinterface

// File: rtl/vga_pixel_tick.sv
// Mod-4 pixel-rate divider: one-clk p_tick every fourth clk.
// Used only when VGA_SYNC_CLKDIV_EN is defined.
module vga_pixel_tick (
    input  logic clk,
    input  logic rst,
    output logic p_tick
);

    logic [1:0] div_q;

    // free-running divider, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= 2'd0;
        end else begin
            div_q <= div_q + 2'd1;
        end
    end

    assign p_tick = (div_q == 2'd3);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters with zero-skew hsync/vsync.
// Macro VGA_SYNC_CLKDIV_EN: divide clk by 4 for p_tick, else p_tick=1.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic     clk,
    input  logic     rst,
    vga_sync_if.master vga
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   p_tick;
    coord_t x_q;
    coord_t y_q;
    coord_t x_nx;
    coord_t y_nx;
    logic   hs_q;
    logic   vs_q;

`ifdef VGA_SYNC_CLKDIV_EN
    vga_pixel_tick u_tick (
        .clk    (clk),
        .rst    (rst),
        .p_tick (p_tick)
    );
`else
    assign p_tick = 1'b1;
`endif

    // next position: wrap x at line end, wrap y with x at frame end
    always_comb begin
        x_nx = x_q + coord_t'(1);
        y_nx = y_q;
        if (x_q == H_LAST) begin
            x_nx = '0;
            y_nx = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
        end
    end

    // counters and syncs advance together, syncs decoded from next count
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (p_tick) begin
            x_q  <= x_nx;
            y_q  <= y_nx;
            hs_q <= !((x_nx >= HS_LO) && (x_nx <= HS_HI));
            vs_q <= !((y_nx >= VS_LO) && (y_nx <= VS_HI));
        end
    end

    assign vga.hsync      = hs_q;
    assign vga.vsync      = vs_q;
    assign vga.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
    assign vga.p_tick     = p_tick;
    assign vga.frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);
    assign vga.pixel_x    = x_q;
    assign vga.pixel_y    = y_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced timing.
// Expected state derives from pixel count since reset release.
module tb_vga_sync_gen;
    import vga_pkg::*;

    localparam int HD = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VD = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int HS_LO = HD + HF;
    localparam int VS_LO = VD + VF;
`ifdef VGA_SYNC_CLKDIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif
    localparam int NCYC = 8000;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       ft;
    } sig_t;

    typedef struct {
        sig_t s;
        logic rst_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;
    bit   mid_done = 1'b0;

    always #5 clk = ~clk;

    vga_sync_if vif ();

    vga_sync_gen #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    function automatic sig_t model(int k);
        sig_t s;
        int pos, x, y;
        pos   = (k / DIV) % (HT * VT);
        x     = pos % HT;
        y     = pos / HT;
        s.x   = 10'(x);
        s.y   = 10'(y);
        s.hs  = !(x >= HS_LO && x < HS_LO + HS);
        s.vs  = !(y >= VS_LO && y < VS_LO + VS);
        s.von = (x < HD) && (y < VD);
        s.pt  = (DIV == 1) ? 1'b1 : (k % DIV == DIV - 1);
        s.ft  = s.pt && (pos == HT * VT - 1);
        return s;
    endfunction

    task automatic push(input sig_t s, input logic re);
        exp_t e;
        e.s = s;
        e.rst_edge = re;
        q.push_back(e);
    endtask

    // stimulus: random resets plus one forced reset inside both sync pulses
    initial begin
        int   k;
        int   hold;
        logic used;
        sig_t s;
        k = 0;
        hold = 0;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 push(model(0), 1'b1);
        end
        rst = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            used = rst;
            @(posedge clk);
            #1;
            if (!used) k = 0;
            else k++;
            s = model(k);
            push(s, !used);
            if (!mid_done && c > NCYC / 2 &&
                int'(s.x) == HS_LO + 2 && int'(s.y) == VS_LO) begin
                hold = 1;
                mid_done = 1'b1;
            end else if (hold == 0 && $urandom_range(0, 1999) == 0) begin
                hold = $urandom_range(1, 3);
            end
            if (hold > 0) begin
                rst = 1'b0;
                hold--;
            end else begin
                rst = 1'b1;
            end
        end
        stim_done = 1'b1;
    end

    // monitor: pop one expectation per clk and compare at negedge
    initial begin
        exp_t e;
        sig_t a;
        int   mcyc;
        int   last_ft;
        int   gaps;
        mcyc = 0;
        last_ft = -1;
        gaps = 0;
        while (!(stim_done && q.size() == 0)) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                mcyc++;
                a = {vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync,
                     vif.video_on, vif.p_tick, vif.frame_tick};
                total++;
                if (a !== e.s) begin
                    bad++;
                    $display("FAIL state cyc=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
                        mcyc, a.x, a.y, a.hs, a.vs, a.von, a.pt, a.ft,
                        e.s.x, e.s.y, e.s.hs, e.s.vs, e.s.von, e.s.pt,
                        e.s.ft);
                end
                if (e.rst_edge) last_ft = -1;
                if (a.ft === 1'b1) begin
                    if (last_ft >= 0) begin
                        gaps++;
                        total++;
                        if (mcyc - last_ft != HT * VT * DIV) begin
                            bad++;
                            $display("FAIL frame_gap got=%0d want=%0d",
                                mcyc - last_ft, HT * VT * DIV);
                        end
                    end
                    last_ft = mcyc;
                end
            end
        end
        total++;
        if (gaps < 1) begin
            bad++;
            $display("FAIL frame_gap_count got=%0d want>=1", gaps);
        end
        total++;
        if (!mid_done) begin
            bad++;
            $display("FAIL mid_reset got=0 want=1");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #((NCYC + 100) * 10 * 2);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have the parameter H_DISPLAY, default 640, giving the visible pixels per line.
REQ-002 The block SHALL have the parameter H_FRONT, default 16, giving the horizontal front-porch pixels.
REQ-003 The block SHALL have the parameter H_SYNC, default 96, giving the hsync pulse width in pixels.
REQ-004 The block SHALL have the parameter H_BACK, default 48, giving the horizontal back-porch pixels.
REQ-005 The block SHALL have the parameter V_DISPLAY, default 480, giving the visible lines per frame.
REQ-006 The block SHALL have the parameter V_FRONT, default 10, giving the vertical front-porch lines.
REQ-007 The block SHALL have the parameter V_SYNC, default 2, giving the vsync pulse width in lines.
REQ-008 The block SHALL have the parameter V_BACK, default 33, giving the vertical back-porch lines.
REQ-009 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-010 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-low.
REQ-011 The block SHALL have the port hsync, output, 1 bit: horizontal sync, registered, active-low.
REQ-012 The block SHALL have the port vsync, output, 1 bit: vertical sync, registered, active-low.
REQ-013 The block SHALL have the port video_on, output, 1 bit: high while the current pixel is in the visible region.
REQ-014 The block SHALL have the port p_tick, output, 1 bit: pixel-rate enable, a single-clk pulse.
REQ-015 The block SHALL have the port frame_tick, output, 1 bit: single-clk pulse at end of frame.
REQ-016 The block SHALL have the port pixel_x, output, 10 bits: current column, 0 to H_TOTAL-1.
REQ-017 The block SHALL have the port pixel_y, output, 10 bits: current line, 0 to V_TOTAL-1.

Function
REQ-018 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800), and V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525); both SHALL be at most 1024, so that 10-bit counters suffice.
REQ-019 pixel_x SHALL advance only on clk edges where p_tick=1; at H_TOTAL-1 it SHALL wrap to 0 and pixel_y SHALL advance.
REQ-020 pixel_y SHALL wrap from V_TOTAL-1 to 0 on the same p_tick on which pixel_x wraps from H_TOTAL-1, so that both counters wrap simultaneously at the frame end.
REQ-021 hsync SHALL be 0 exactly while pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] ([656,751]), and 1 otherwise.
REQ-022 vsync SHALL be 0 exactly while pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] ([490,491]), and 1 otherwise.
REQ-023 hsync and vsync SHALL be registered from the next-count values, so that they change on the same clk edge as pixel_x and pixel_y (zero relative skew).
REQ-024 video_on SHALL equal (pixel_x < H_DISPLAY) AND (pixel_y < V_DISPLAY), decoded combinationally from the count registers.
REQ-025 frame_tick SHALL be 1 for exactly one clk, namely the clk where p_tick=1, pixel_x=H_TOTAL-1 and pixel_y=V_TOTAL-1; it SHALL be 0 at all other times.
REQ-026 The counters SHALL hold their values between p_ticks, and no output SHALL change except on a p_tick edge or on reset.
REQ-027 Downstream animation logic SHALL use frame_tick as its per-frame refresh enable, which guarantees one update per frame regardless of the clk/p_tick ratio.

Reset
REQ-028 On a clk edge with rst=0, the block SHALL set pixel_x=0, pixel_y=0, hsync=1, vsync=1, the divider to 0, p_tick=0 and frame_tick=0.
REQ-029 Immediately after reset, video_on SHALL be 1, because the count 0,0 is visible.
REQ-030 Reset asserted mid-frame SHALL take effect on the next clk edge, without completing the current line.
REQ-031 The first p_tick after rst returns to 1 SHALL occur per REQ-033 or REQ-034, counting from divider 0.

Configuration
REQ-032 The macro VGA_SYNC_CLKDIV_EN SHALL select the pixel-rate source.
REQ-033 With VGA_SYNC_CLKDIV_EN defined, a 2-bit mod-4 divider SHALL generate p_tick, high for one clk out of every 4 (100 MHz clk giving 25 MHz pixels); the first p_tick SHALL occur on the 4th clk after reset release.
REQ-034 With VGA_SYNC_CLKDIV_EN undefined, p_tick SHALL be tied to 1 (clk is the 25 MHz pixel clock), so the counters advance every clk.

Structure
REQ-035 A shared package vga_pkg SHALL hold the default timing constants, H_TOTAL and V_TOTAL, and the 10-bit coordinate width.
REQ-036 The divider SHALL be a single sub-module, vga_pixel_tick (inputs clk and rst, output p_tick), instantiated only under VGA_SYNC_CLKDIV_EN.

Verification
REQ-037 Reset test: with CLKDIV_EN, hold rst=0 for 5 clk, then release -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, and the first p_tick appears on clk 4.
REQ-038 Line timing test: run one line -> hsync falls when pixel_x=656, rises when pixel_x=752, and stays low for 96 p_ticks (384 clk with CLKDIV_EN); video_on falls when pixel_x=640.
REQ-039 Wrap test: at pixel_x=799, pixel_y=10, apply a p_tick -> pixel_x=0, pixel_y=11, and hsync is 1 on the same edge.
REQ-040 Frame test: run a full frame -> vsync is low only for pixel_y 490-491, frame_tick pulses exactly once, and frame_tick spacing is 420,000 p_ticks (1,680,000 clk with CLKDIV_EN).
REQ-041 Mid-frame reset test: assert rst=0 at pixel_x=700, pixel_y=490 (hsync=0, vsync=0) -> one edge later, all outputs are at their reset values, with hsync=1 and vsync=1.
REQ-042 No-divider build test: compile without CLKDIV_EN -> p_tick is constantly 1 and pixel_x increments every clk.
